// File: rtl/sm_muldiv_if.sv
// Bus between the CPU core and the multiply/divide unit.
// The CPU drives the master side; the unit drives the slave side.
interface sm_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             hiWe;
  logic             loWe;
  logic [WIDTH-1:0] wData;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, srcA, srcB, hiWe, loWe, wData,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, srcA, srcB, hiWe, loWe, wData,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/sm_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO for schoolMIPS.
// Works on operand magnitudes for WIDTH cycles, then applies sign correction.
module sm_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  sm_muldiv_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t             state, state_next;
  logic [1:0]         op_q;
  logic               neg_q;
  logic               sign_a_q;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic [WIDTH-1:0]   rem_diff;
  logic               rem_ge;
  logic [2*WIDTH-1:0] acc_step, prod_neg;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (cnt == CNT_W'(1)) state_next = SIGN;
      SIGN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // acc holds {partial product, multiplier} for MULT and {remainder, dividend/quotient} for DIV
  always_comb begin
    a_mag    = (bus.op[0] && bus.srcA[WIDTH-1]) ? -bus.srcA : bus.srcA;
    b_mag    = (bus.op[0] && bus.srcB[WIDTH-1]) ? -bus.srcB : bus.srcB;
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_ge   = rem_sh >= {1'b0, opnd};
    rem_diff = rem_sh[WIDTH-1:0] - opnd;
    if (op_q[1])
      acc_step = rem_ge ? {rem_diff, acc[WIDTH-2:0], 1'b1}
                        : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    prod_neg = -acc;
    // a zero divisor leaves quotient all ones and remainder equal to the raw dividend
    quo_fix  = (neg_q && opnd != '0) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = sign_a_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      cnt      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      busy_q <= (state_next != IDLE);
      done_q <= (state == SIGN);
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q     <= bus.op;
            sign_a_q <= bus.op[0] & bus.srcA[WIDTH-1];
            neg_q    <= bus.op[0] & (bus.srcA[WIDTH-1] ^ bus.srcB[WIDTH-1]);
            opnd     <= bus.op[1] ? b_mag : a_mag;
            acc      <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
            cnt      <= CNT_W'(WIDTH);
          end else begin
            if (bus.hiWe) hi_q <= bus.wData;
            if (bus.loWe) lo_q <= bus.wData;
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt - CNT_W'(1);
        end
        SIGN: begin
          if (op_q[1]) begin
            lo_q <= quo_fix;
            hi_q <= rem_fix;
          end else if (neg_q) begin
            {hi_q, lo_q} <= prod_neg;
          end else begin
            {hi_q, lo_q} <= acc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_sm_muldiv.sv
// Scoreboard bench for sm_muldiv at WIDTH=32 and WIDTH=8.
module tb_sm_muldiv;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sm_muldiv_if #(.WIDTH(32)) b32 ();
  sm_muldiv_if #(.WIDTH(8))  b8 ();

  sm_muldiv #(.WIDTH(32), .CNT_W(6)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  sm_muldiv #(.WIDTH(8),  .CNT_W(4)) u8  (.clk(clk), .rst_n(rst_n), .bus(b8));

  int          checks = 0;
  int          failures = 0;
  logic [63:0] sb32[$];
  logic [15:0] sb8[$];
  logic [63:0] m32 = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: return {32'b0, a} * {32'b0, b};
      2'b01: return 64'(sa * sb);
      2'b10: return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
    endcase
  endfunction

  function automatic logic [15:0] model8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (o)
      2'b00: return {8'b0, a} * {8'b0, b};
      2'b01: return 16'(sa * sb);
      2'b10: return (b == 0) ? {a, 8'hFF} : {a % b, a / b};
      default: begin
        if (b == 0) return {a, 8'hFF};
        if (a == 8'h80 && b == 8'hFF) return {8'h00, 8'h80};
        return {8'(sa % sb), 8'(sa / sb)};
      end
    endcase
  endfunction

  initial begin : mon32
    int bc;
    logic [63:0] e;
    bc = 0;
    forever begin
      @(negedge clk);
      if (b32.done) begin
        if (sb32.size() == 0) check("u32_spurious_done", 1, 0);
        else begin
          e = sb32.pop_front();
          check("u32_hi", b32.hi, e[63:32]);
          check("u32_lo", b32.lo, e[31:0]);
          check("u32_busy_cycles", bc, 33);
          m32 = e;
        end
        bc = 0;
      end else if (b32.busy) begin
        bc++;
        check("u32_hold", {b32.hi, b32.lo}, m32);
      end else bc = 0;
    end
  end

  initial begin : mon8
    int bc;
    logic [15:0] e;
    bc = 0;
    forever begin
      @(negedge clk);
      if (b8.done) begin
        if (sb8.size() == 0) check("u8_spurious_done", 1, 0);
        else begin
          e = sb8.pop_front();
          check("u8_hi", b8.hi, e[15:8]);
          check("u8_lo", b8.lo, e[7:0]);
          check("u8_busy_cycles", bc, 9);
        end
        bc = 0;
      end else if (b8.busy) bc++;
      else bc = 0;
    end
  end

  task automatic start32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input logic hw);
    int n = 0;
    @(negedge clk);
    while (b32.busy && n < 100) begin @(negedge clk); n++; end
    if (b32.busy) check("u32_idle_timeout", 0, 1);
    b32.start = 1'b1; b32.op = o; b32.srcA = a; b32.srcB = b;
    b32.hiWe = hw; b32.wData = 32'hDEAD_BEEF;
    sb32.push_back(exp);
    @(negedge clk);
    b32.start = 1'b0; b32.hiWe = 1'b0;
    b32.srcA = $urandom; b32.srcB = $urandom;
  endtask

  task automatic finish32();
    int n = 0;
    do begin @(negedge clk); n++; end while (!b32.done && n < 100);
    if (!b32.done) check("u32_done_timeout", 0, 1);
  endtask

  task automatic run32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    start32(o, a, b, exp, 1'b0);
    finish32();
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    int n = 0;
    @(negedge clk);
    b8.start = 1'b1; b8.op = o; b8.srcA = a; b8.srcB = b;
    sb8.push_back(exp);
    @(negedge clk);
    b8.start = 1'b0; b8.srcA = 8'($urandom); b8.srcB = 8'($urandom);
    do begin @(negedge clk); n++; end while (!b8.done && n < 50);
    if (!b8.done) check("u8_done_timeout", 0, 1);
  endtask

  task automatic move32(input logic hw, input logic lw, input logic [31:0] d);
    @(negedge clk);
    b32.hiWe = hw; b32.loWe = lw; b32.wData = d;
    if (hw) m32[63:32] = d;
    if (lw) m32[31:0] = d;
    @(negedge clk);
    b32.hiWe = 1'b0; b32.loWe = 1'b0;
    check("mt_hi", b32.hi, m32[63:32]);
    check("mt_lo", b32.lo, m32[31:0]);
  endtask

  initial begin
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [7:0]  a8, b8v;
    rst_n = 1'b0;
    b32.start = 1'b0; b32.op = '0; b32.srcA = '0; b32.srcB = '0;
    b32.hiWe = 1'b0; b32.loWe = 1'b0; b32.wData = '0;
    b8.start = 1'b0; b8.op = '0; b8.srcA = '0; b8.srcB = '0;
    b8.hiWe = 1'b0; b8.loWe = 1'b0; b8.wData = '0;
    #12;
    check("rst_busy", b32.busy, 0);
    check("rst_done", b32.done, 0);
    check("rst_hilo", {b32.hi, b32.lo}, 0);
    check("rst8_hilo", {b8.busy, b8.hi, b8.lo}, 0);
    rst_n = 1'b1;

    move32(1'b1, 1'b1, 32'h1234);
    move32(1'b1, 1'b0, 32'hA5A5);

    run32(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
    run32(2'b01, 32'hFFFF_FFFD, 32'd5,         {32'hFFFF_FFFF, 32'hFFFF_FFF1});
    run32(2'b11, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run32(2'b10, 32'd7,         32'd2,         {32'd1, 32'd3});
    run32(2'b10, 32'd7,         32'd0,         {32'd7, 32'hFFFF_FFFF});
    run32(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
    run32(2'b11, 32'hFFFF_FFF9, 32'd0,         {32'hFFFF_FFF9, 32'hFFFF_FFFF});

    start32(2'b00, 32'd3, 32'd4, {32'd0, 32'd12}, 1'b1);
    check("start_wins_hi", b32.hi, m32[63:32]);
    finish32();

    start32(2'b01, 32'hFFFF_FF00, 32'h0001_0003, model32(2'b01, 32'hFFFF_FF00, 32'h0001_0003), 1'b0);
    repeat (5) @(negedge clk);
    b32.start = 1'b1; b32.op = 2'b10; b32.srcA = 32'd1; b32.srcB = 32'd1;
    b32.hiWe = 1'b1; b32.loWe = 1'b1; b32.wData = 32'h5555_5555;
    @(negedge clk);
    b32.start = 1'b0; b32.hiWe = 1'b0; b32.loWe = 1'b0;
    finish32();

    start32(2'b00, 32'hFFFF_FFFF, 32'h0001_2345, 64'h0, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", b32.busy, 0);
    check("abort_done", b32.done, 0);
    check("abort_hilo", {b32.hi, b32.lo}, 0);
    sb32.delete();
    m32 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run32(2'b00, 32'd6, 32'd7, {32'd0, 32'd42});

    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      if (i % 5 == 0) b = -b;
      run32(o, a, b, model32(o, a, b));
    end

    run8(2'b01, 8'h80, 8'h80, {8'h40, 8'h00});
    run8(2'b11, 8'h80, 8'h03, {8'hFE, 8'hD6});
    run8(2'b11, 8'h80, 8'hFF, {8'h00, 8'h80});
    for (int i = 0; i < 16; i++) begin
      o   = 2'($urandom_range(0, 3));
      a8  = 8'($urandom);
      b8v = 8'($urandom_range(0, 255));
      run8(o, a8, b8v, model8(o, a8, b8v));
    end

    repeat (3) @(negedge clk);
    check("sb32_empty", sb32.size(), 0);
    check("sb8_empty", sb8.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sm_muldiv.md
Name: sm_muldiv

Overview:
- Iterative multiply/divide unit that owns the HI/LO registers for the schoolMIPS core.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and supports direct MTHI/MTLO writes.
- Sits beside the single-cycle ALU. The CPU stalls its PC while busy is high, then reads hi/lo for MFHI/MFLO.
- Operand width is parametrised.

Parameters:
- WIDTH, 32, operand and HI/LO width. Must be even and at least 4.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin operation; sampled only in IDLE
- op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- srcA  input  WIDTH  multiplicand / dividend (rs)
- srcB  input  WIDTH  multiplier / divisor (rt)
- hiWe  input  1  MTHI write enable
- loWe  input  1  MTLO write enable
- wData  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in progress; CPU must stall
- done  output  1  one-cycle pulse when hi/lo are updated by an operation
- hi  output  WIDTH  HI register (product upper half / remainder)
- lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
  - Reset forces state=IDLE and zeroes hi, lo, busy, done, the counter and all datapath registers.
  - Asserting reset mid-operation aborts the operation. No partial result reaches hi/lo.
- All outputs are registered. busy = (state != IDLE).
- State machine: IDLE -> CALC -> SIGN -> IDLE.
- IDLE:
  - If start=1 at a clock edge (E0): latch op, sign flags and operand magnitudes (abs value for signed ops, raw for unsigned), set counter=WIDTH, go to CALC.
  - If start=0: hiWe writes wData to hi and loWe writes wData to lo. Both may be set in the same cycle.
  - If start and hiWe/loWe are asserted together, start wins and the writes are dropped.
- CALC: one iteration per edge, counter decrements, exits to SIGN after exactly WIDTH edges (E1..EWIDTH).
  - Multiply: shift-add on magnitudes into a 2*WIDTH accumulator.
  - Divide: restoring division on magnitudes, one quotient bit per edge.
- SIGN: one edge (EWIDTH+1), then return to IDLE with done=1 for exactly one cycle.
  - MULT: negate the 2*WIDTH product if the operand signs differ. hi=upper half, lo=lower half.
  - DIV: negate the quotient if the signs differ. The remainder takes the dividend's sign.
  - Unsigned ops: no correction.
- Latency and pacing:
  - busy is high for WIDTH+1 cycles.
  - hi/lo hold their old values until the SIGN edge and are valid in the done cycle.
  - The earliest next start is accepted at the edge ending the done cycle.
- Ignored while busy: start, hiWe and loWe. Operand inputs may change after E0 without effect.
- Divide by zero (DIV or DIVU): lo=all ones, hi=srcA as latched, no sign correction. Timing is unchanged.
- DIV of the most negative number by -1: lo=most negative number, hi=0. No trap.
- Arithmetic is modulo 2^WIDTH per half. There are no exception outputs.

Test Plan:
- Unsigned multiply, WIDTH=32: MULTU 0xFFFFFFFF x 0xFFFFFFFF, start at E0.
  - busy high for 33 cycles, done pulses once.
  - hi=0xFFFFFFFE, lo=0x00000001 in the done cycle.
  - hi/lo unchanged before the done cycle.
- Signed multiply and divide:
  - MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7 / 2 -> lo=3, hi=1.
- Corner cases:
  - DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=7.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - Both take 33 busy cycles.
- Moves and contention:
  - Idle with hiWe=loWe=1, wData=0x1234 -> hi=lo=0x1234 next cycle.
  - hiWe with start together -> write dropped, operation runs.
  - hiWe or start pulsed mid-operation -> ignored, results match a clean run.
- Reset mid-operation: assert rst_n=0 asynchronously at E10 of a MULTU.
  - busy, done, hi and lo are 0 immediately.
  - After release, a fresh MULTU 6 x 7 gives hi=0, lo=42.
- Parametrisation, WIDTH=8, CNT_W=4:
  - MULT 0x80 x 0x80 -> hi=0x40, lo=0x00.
  - DIV 0x80 / 0x03 -> lo=0xD6, hi=0xFE.
  - busy is high for 9 cycles.
